// File: rtl/psum_quant_pack.sv
// Requantizes 16-lane 32-bit partial sums to int8 and emits them as a nonzero flag word plus zero-compacted data.
// Latency: 2 cycles (S1 quantize, S2 pack); one word per cycle sustained.
// Backpressure: S1/S2 advance only when S2 is empty or ACTGB_rdy=1; PSUMGB_rdy deasserts when both stages are full.
module psum_quant_pack #(
    parameter int NUM_LANE    = 16,
    parameter int PSUM_WIDTH  = 32,
    parameter int DATA_WIDTH  = 8,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [SHIFT_WIDTH-1:0]         CFG_shift,
    input  logic                           CFG_relu,
    input  logic                           PSUMGB_val,
    output logic                           PSUMGB_rdy,
    input  logic [NUM_LANE*PSUM_WIDTH-1:0] PSUMGB_data,
    output logic                           ACTGB_val,
    input  logic                           ACTGB_rdy,
    output logic [NUM_LANE*DATA_WIDTH-1:0] ACTGB_data,
    output logic [NUM_LANE-1:0]            FLGACTGB_data,
    output logic [15:0]                    ACTGB_cnt
);

    localparam int EXT   = PSUM_WIDTH + 1;
    localparam int SLOTW = $clog2(NUM_LANE) + 1;
    localparam logic signed [EXT-1:0] QMAX = EXT'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [EXT-1:0] QMIN = ~QMAX;

    // One extra bit keeps x + 2^(s-1) from overflowing near the positive limit.
    function automatic logic [DATA_WIDTH-1:0] quant(
        input logic [PSUM_WIDTH-1:0]  p,
        input logic [SHIFT_WIDTH-1:0] s,
        input logic                   relu
    );
        logic signed [EXT-1:0] x;
        logic signed [EXT-1:0] rnd;
        logic signed [EXT-1:0] y;
        x   = {p[PSUM_WIDTH-1], p};
        rnd = '0;
        if (s != '0)
            rnd = EXT'(1) << (s - 1'b1);
        y = (x + rnd) >>> s;
        if (relu && y < 0)
            y = '0;
        if (y > QMAX)
            y = QMAX;
        else if (y < QMIN)
            y = QMIN;
        return y[DATA_WIDTH-1:0];
    endfunction

    logic                                     s1_vld;
    logic [NUM_LANE-1:0][DATA_WIDTH-1:0]      s1_q;
    logic [NUM_LANE-1:0][DATA_WIDTH-1:0]      qnt;
    logic                                     s2_vld;
    logic [NUM_LANE-1:0]                      s2_flag;
    logic [NUM_LANE*DATA_WIDTH-1:0]           s2_dat;
    logic [NUM_LANE-1:0]                      pk_flag;
    logic [NUM_LANE*DATA_WIDTH-1:0]           pk_dat;
    logic [SLOTW-1:0]                         slot;
    logic                                     s2_adv;
    logic [15:0]                              cnt;

    assign s2_adv     = ~s2_vld | ACTGB_rdy;
    assign PSUMGB_rdy = rst_n & (~s1_vld | s2_adv);

    always_comb begin
        qnt = '0;
        for (int i = 0; i < NUM_LANE; i++)
            qnt[i] = quant(PSUMGB_data[PSUM_WIDTH*i +: PSUM_WIDTH], CFG_shift, CFG_relu);
    end

    always_comb begin
        pk_flag = '0;
        pk_dat  = '0;
        slot    = '0;
        for (int i = 0; i < NUM_LANE; i++) begin
            if (s1_q[i] != '0) begin
                pk_flag[i] = 1'b1;
                pk_dat[slot*DATA_WIDTH +: DATA_WIDTH] = s1_q[i];
                slot = slot + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s1_q   <= '0;
        end else if (PSUMGB_rdy) begin
            s1_vld <= PSUMGB_val;
            if (PSUMGB_val)
                s1_q <= qnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld  <= 1'b0;
            s2_flag <= '0;
            s2_dat  <= '0;
        end else if (s2_adv) begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_flag <= pk_flag;
                s2_dat  <= pk_dat;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (s2_vld && ACTGB_rdy)
            cnt <= cnt + 16'd1;
    end

    assign ACTGB_val     = s2_vld;
    assign ACTGB_data    = s2_dat;
    assign FLGACTGB_data = s2_flag;
    assign ACTGB_cnt     = cnt;

endmodule

// File: tb/tb_psum_quant_pack.sv
// Bench for psum_quant_pack: arithmetic reference model with an expectation queue plus directed literal checks.
module tb_psum_quant_pack;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [4:0]   CFG_shift;
    logic         CFG_relu;
    logic         PSUMGB_val;
    logic         PSUMGB_rdy;
    logic [511:0] PSUMGB_data;
    logic         ACTGB_val;
    logic         ACTGB_rdy;
    logic [127:0] ACTGB_data;
    logic [15:0]  FLGACTGB_data;
    logic [15:0]  ACTGB_cnt;

    psum_quant_pack dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .CFG_shift    (CFG_shift),
        .CFG_relu     (CFG_relu),
        .PSUMGB_val   (PSUMGB_val),
        .PSUMGB_rdy   (PSUMGB_rdy),
        .PSUMGB_data  (PSUMGB_data),
        .ACTGB_val    (ACTGB_val),
        .ACTGB_rdy    (ACTGB_rdy),
        .ACTGB_data   (ACTGB_data),
        .FLGACTGB_data(FLGACTGB_data),
        .ACTGB_cnt    (ACTGB_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0]  flg;
        logic [127:0] dat;
    } exp_t;

    int   checks   = 0;
    int   failures = 0;
    int   stalls   = 0;
    int   model_cnt = 0;
    exp_t expq[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Plain integer arithmetic: round half up, then ReLU, then clamp to int8.
    function automatic int quant(input int x, input int s, input bit r);
        longint v;
        v = x;
        if (s > 0)
            v = (v + (longint'(1) << (s - 1))) >>> s;
        if (r && v < 0)
            v = 0;
        if (v > 127)
            v = 127;
        if (v < -128)
            v = -128;
        return int'(v);
    endfunction

    function automatic exp_t model(input logic [511:0] d, input int s, input bit r);
        exp_t e;
        int   k;
        int   q;
        e = '0;
        k = 0;
        for (int i = 0; i < 16; i++) begin
            q = quant(int'(signed'(d[32*i +: 32])), s, r);
            if (q != 0) begin
                e.flg[i]       = 1'b1;
                e.dat[8*k +: 8] = q[7:0];
                k++;
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            expq.delete();
            model_cnt = 0;
        end else begin
            chk("cnt_track", {112'd0, ACTGB_cnt}, {112'd0, model_cnt[15:0]});
            if (ACTGB_val) begin
                if (expq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out actual flag=%h data=%h required none", FLGACTGB_data, ACTGB_data);
                end else begin
                    chk("out_flag", {112'd0, FLGACTGB_data}, {112'd0, expq[0].flg});
                    chk("out_data", ACTGB_data, expq[0].dat);
                    if (ACTGB_rdy) begin
                        void'(expq.pop_front());
                        model_cnt++;
                    end
                end
            end
            if (PSUMGB_val && PSUMGB_rdy)
                expq.push_back(model(PSUMGB_data, int'(CFG_shift), CFG_relu));
        end
    end

    // Called just after a posedge; returns just after the accepting posedge.
    task automatic send(input logic [511:0] d, input int s, input bit r);
        int waited;
        waited      = 0;
        PSUMGB_data = d;
        CFG_shift   = s[4:0];
        CFG_relu    = r;
        PSUMGB_val  = 1'b1;
        @(negedge clk);
        while (!PSUMGB_rdy && waited < 200) begin
            stalls++;
            waited++;
            @(negedge clk);
        end
        if (!PSUMGB_rdy) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual rdy=0 after %0d cycles required rdy=1", waited);
        end
        @(posedge clk);
        #1;
        PSUMGB_val = 1'b0;
    endtask

    task automatic handshake();
        ACTGB_rdy = 1'b1;
        @(posedge clk);
        #1;
        ACTGB_rdy = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    logic [511:0] w;
    logic [127:0] exp_dat;
    logic [127:0] snap_dat;
    logic [15:0]  snap_flg;
    exp_t         e3;

    initial begin
        rst_n       = 1'b0;
        CFG_shift   = '0;
        CFG_relu    = 1'b0;
        PSUMGB_val  = 1'b0;
        PSUMGB_data = '0;
        ACTGB_rdy   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_val", {127'd0, ACTGB_val}, 128'd0);
        chk("rst_rdy", {127'd0, PSUMGB_rdy}, 128'd0);
        chk("rst_cnt", {112'd0, ACTGB_cnt}, 128'd0);
        chk("rst_flag", {112'd0, FLGACTGB_data}, 128'd0);
        chk("rst_data", ACTGB_data, 128'd0);

        chk("model_q5", 128'(quant(5, 2, 0)), 128'(1));
        chk("model_q6", 128'(quant(6, 2, 0)), 128'(2));
        chk("model_qm6", 128'(quant(-6, 2, 0)), 128'(-1));
        chk("model_qmax", 128'(quant(32'h7FFFFFFF, 2, 0)), 128'(127));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single word, two-edge latency
        for (int i = 0; i < 16; i++)
            w[32*i +: 32] = 32'h00000100;
        send(w, 4, 1'b0);
        @(posedge clk);
        #1;
        chk("t1_val", {127'd0, ACTGB_val}, 128'd1);
        chk("t1_flag", {112'd0, FLGACTGB_data}, 128'hFFFF);
        exp_dat = {16{8'h10}};
        chk("t1_data", ACTGB_data, exp_dat);
        handshake();
        chk("t1_cnt", {112'd0, ACTGB_cnt}, 128'd1);

        // Rounding and saturation
        w = '0;
        w[0*32 +: 32] = 32'd5;
        w[1*32 +: 32] = 32'd6;
        w[2*32 +: 32] = -32'sd6;
        w[3*32 +: 32] = 32'd1000;
        w[4*32 +: 32] = -32'sd1000;
        w[5*32 +: 32] = 32'h7FFFFFFF;
        send(w, 2, 1'b0);
        @(posedge clk);
        #1;
        chk("t2_flag", {112'd0, FLGACTGB_data}, 128'h003F);
        chk("t2_data", ACTGB_data, 128'h7F807FFF0201);
        handshake();

        // Sparse pack with ReLU
        w = '0;
        w[3*32 +: 32]  = 32'd7;
        w[9*32 +: 32]  = -32'sd4;
        w[12*32 +: 32] = -32'sd9;
        e3 = model(w, 0, 1'b1);
        chk("model_t3_flag", {112'd0, e3.flg}, 128'h0008);
        send(w, 0, 1'b1);
        @(posedge clk);
        #1;
        chk("t3_flag", {112'd0, FLGACTGB_data}, 128'h0008);
        chk("t3_data", ACTGB_data, 128'h07);
        handshake();

        // Backpressure: five words against a stalled consumer
        pulse_reset();
        for (int n = 0; n < 2; n++) begin
            for (int i = 0; i < 16; i++)
                w[32*i +: 32] = 32'(n * 64 + i * 16);
            send(w, 3, 1'b0);
        end
        snap_dat = ACTGB_data;
        snap_flg = FLGACTGB_data;
        fork
            begin
                for (int n = 2; n < 5; n++) begin
                    for (int i = 0; i < 16; i++)
                        w[32*i +: 32] = 32'(n * 64 + i * 16);
                    send(w, 3, 1'b0);
                end
            end
            begin
                repeat (4) begin
                    @(negedge clk);
                    chk("t4_rdy_low", {127'd0, PSUMGB_rdy}, 128'd0);
                    chk("t4_val_hold", {127'd0, ACTGB_val}, 128'd1);
                    chk("t4_data_hold", ACTGB_data, snap_dat);
                    chk("t4_flag_hold", {112'd0, FLGACTGB_data}, {112'd0, snap_flg});
                end
                @(posedge clk);
                #1;
                ACTGB_rdy = 1'b1;
            end
        join
        repeat (6) @(posedge clk);
        #1;
        chk("t4_cnt", {112'd0, ACTGB_cnt}, 128'd5);
        chk("t4_drained", 128'(expq.size()), 128'd0);

        // Continuous stream with shift toggling every word
        stalls = 0;
        for (int n = 0; n < 100; n++) begin
            for (int i = 0; i < 16; i++) begin
                if ($urandom_range(0, 3) == 0)
                    w[32*i +: 32] = '0;
                else if ($urandom_range(0, 1) == 0)
                    w[32*i +: 32] = 32'($urandom_range(0, 4000)) - 32'd2000;
                else
                    w[32*i +: 32] = $urandom;
            end
            send(w, (n % 2 == 0) ? 3 : 20, ((n / 2) % 2) == 1);
        end
        repeat (5) @(posedge clk);
        #1;
        chk("t5_no_stall", 128'(stalls), 128'd0);
        chk("t5_cnt", {112'd0, ACTGB_cnt}, 128'd105);
        chk("t5_drained", 128'(expq.size()), 128'd0);

        // Asynchronous reset with words in flight
        ACTGB_rdy = 1'b0;
        for (int n = 0; n < 2; n++) begin
            for (int i = 0; i < 16; i++)
                w[32*i +: 32] = 32'(100 + n * 300 + i);
            send(w, 0, 1'b0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_val_async", {127'd0, ACTGB_val}, 128'd0);
        chk("t6_cnt_async", {112'd0, ACTGB_cnt}, 128'd0);
        chk("t6_rdy_async", {127'd0, PSUMGB_rdy}, 128'd0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        ACTGB_rdy = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("t6_no_stale", {127'd0, ACTGB_val}, 128'd0);
        chk("t6_cnt_after", {112'd0, ACTGB_cnt}, 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/psum_quant_pack.md
Name: psum_quant_pack

Overview:
- Downstream neighbour of a PEB's PSUM output port.
- Accepts 16-lane 32-bit partial-sum words on the PSUMGB val/rdy handshake.
- Per lane: requantizes to signed 8-bit (rounding shift, optional ReLU, saturation).
- Emits the next layer's activation in sparse form, i.e. a 16-bit nonzero flag word plus a zero-compacted 128-bit activation word, so the result can be written back to the GB in the same format the PEB consumes.

Parameters:
- NUM_LANE, 16, lanes per word.
- PSUM_WIDTH, 32, signed partial-sum width per lane.
- DATA_WIDTH, 8, signed activation width per lane.
- SHIFT_WIDTH, 5, width of the requantization shift amount.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- CFG_shift  in  SHIFT_WIDTH  right-shift amount, 0..31.
- CFG_relu  in  1  1 = clamp negative results to 0.
- PSUMGB_val  in  1  input word valid.
- PSUMGB_rdy  out  1  block can accept an input word.
- PSUMGB_data  in  NUM_LANE*PSUM_WIDTH  lane i at [32*i +: 32], signed.
- ACTGB_val  out  1  output word valid.
- ACTGB_rdy  in  1  consumer accepts output.
- ACTGB_data  out  NUM_LANE*DATA_WIDTH  compacted nonzero activations; slot k at [8*k +: 8].
- FLGACTGB_data  out  NUM_LANE  bit i = 1 iff lane i quantized value is nonzero.
- ACTGB_cnt  out  16  count of output words accepted since reset; wraps 0xFFFF -> 0.

Behaviour:
- Reset (async, rst_n=0): both pipeline valids = 0, ACTGB_val = 0, ACTGB_data = 0, FLGACTGB_data = 0, ACTGB_cnt = 0, PSUMGB_rdy = 0 while rst_n is low. Reset asserted mid-transfer discards all in-flight words; nothing is replayed.
- Pipeline: two registered stages, S1 (quantize) and S2 (pack/output). ACTGB_* are driven directly from S2 registers.
- Stall rules:
  - S2 loads when S2 is empty or ACTGB_rdy=1.
  - S1 advances under the same condition.
  - PSUMGB_rdy = ~S1_valid | S2_advance (purely combinational from internal state and ACTGB_rdy).
  - Full throughput: one word per cycle under continuous val/rdy.
  - Latency: input accepted at edge N gives ACTGB_val=1 after edge N+2 when there is no backpressure.
- Config capture: CFG_shift and CFG_relu are sampled on the accept edge and carried with the word. Changing CFG mid-stream affects only later-accepted words.
- Quantize (S1), per lane, on signed 33-bit extension x:
  - s=0: y = x.
  - s>0: y = (x + 2^(s-1)) >>> s (arithmetic shift, round-half-up).
  - ReLU: if CFG_relu and y<0, y=0.
  - Saturate: y>127 -> 127; y<-128 -> -128.
- Pack (S2):
  - flag[i] = (q[i] != 0).
  - Nonzero q values are placed in ascending lane order into slots 0..popcount-1.
  - Remaining slots = 0.
  - All-zero word: flag = 0, data = 0, still emitted (ACTGB_val=1).
- Holding: while ACTGB_val=1 and ACTGB_rdy=0, ACTGB_data and FLGACTGB_data stay stable.
- Counter: ACTGB_cnt increments on each cycle with ACTGB_val & ACTGB_rdy.
- Simultaneous events: an accept into S1 and a drain of S2 in the same cycle are both honoured; no bubble, no loss, no duplication.

Test Plan:
1. Reset then single word, all lanes = 0x00000100, shift=4, relu=0 -> after 2 edges ACTGB_val=1, FLGACTGB_data=0xFFFF, every slot = 16 (0x10); ACTGB_cnt=1 after the handshake.
2. Rounding/saturation, shift=2, lanes: 5 -> 1, 6 -> 2 (half-up), -6 -> -1, 1000 -> 127, -1000 -> -128, 0x7FFFFFFF -> 127 (no 33-bit overflow).
3. Sparse pack, relu=1, shift=0: lane3=7, lane9=-4, lane12=-9, others 0 -> flag=0x0008, slot0=7, other slots 0.
4. Backpressure: stream 5 words with ACTGB_rdy held 0 -> PSUMGB_rdy drops after 2 accepts, ACTGB outputs stay stable. Release rdy -> all 5 words emitted in order, no duplicates, ACTGB_cnt=5.
5. Continuous streaming with val=rdy=1 for 100 words and CFG_shift toggled every word -> one output per cycle, each word quantized with its own captured shift.
6. Assert rst_n=0 with 2 words in flight -> ACTGB_val=0 and ACTGB_cnt=0 immediately (asynchronous); after release, no stale words appear.
